// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and its datapath.
// The master side is the controller; the slave side is the datapath.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       mem_read;
    logic       mem_write;
    logic       address_select;
    logic       IR_write;
    logic       PC_write;
    logic       reg_write;
    logic [1:0] ALU_A_select;
    logic [1:0] ALU_B_select;
    logic [1:0] result_select;
    logic [2:0] ALU_control;
    logic       illegal;

    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_read, mem_write, address_select, IR_write, PC_write, reg_write,
               ALU_A_select, ALU_B_select, result_select, ALU_control, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_read, mem_write, address_select, IR_write, PC_write, reg_write,
               ALU_A_select, ALU_B_select, result_select, ALU_control, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32-subset control FSM: Moore outputs per state, with PC_write
// in FETCH/BRANCH depending combinationally on mem_ready/zero.
module multicycle_controller (
    input  logic                           clock,
    input  logic                           reset,
    multicycle_controller_if.master        bus
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;

    logic       mem_read, mem_write, address_select;
    logic       ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_a_sel, alu_b_sel, result_sel;
    logic [2:0] alu_ctrl;
    logic       alu_f3_ok, br_f3_ok;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_r);
        case (f3)
            3'b000:  alu_decode = (is_r && f7b5) ? 3'b001 : 3'b000;
            3'b010:  alu_decode = 3'b101;
            3'b110:  alu_decode = 3'b011;
            3'b111:  alu_decode = 3'b010;
            default: alu_decode = 3'b000;
        endcase
    endfunction

    assign alu_f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                       (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);
    assign br_f3_ok  = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        address_select = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        illegal        = 1'b0;
        alu_a_sel      = 2'b00;
        alu_b_sel      = 2'b00;
        result_sel     = 2'b00;
        alu_ctrl       = 3'b000;

        case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_b_sel  = 2'b10;
                result_sel = 2'b10;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                alu_a_sel = 2'b01;
                alu_b_sel = 2'b01;
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_R:              state_d = alu_f3_ok ? EXEC_R : TRAP;
                    OP_I:              state_d = alu_f3_ok ? EXEC_I : TRAP;
                    OP_BRANCH:         state_d = br_f3_ok ? BRANCH : TRAP;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_a_sel = 2'b10;
                alu_b_sel = 2'b01;
                state_d   = bus.opcode[5] ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                address_select = 1'b1;
                mem_read       = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                result_sel = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEM_WRITE: begin
                address_select = 1'b1;
                mem_write      = 1'b1;
                if (bus.mem_ready) state_d = FETCH;
            end
            EXEC_R: begin
                alu_a_sel = 2'b10;
                alu_ctrl  = alu_decode(bus.funct3, bus.funct7b5, 1'b1);
                state_d   = ALU_WB;
            end
            EXEC_I: begin
                alu_a_sel = 2'b10;
                alu_b_sel = 2'b01;
                alu_ctrl  = alu_decode(bus.funct3, bus.funct7b5, 1'b0);
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_a_sel = 2'b10;
                alu_ctrl  = 3'b001;
                // funct3 000 is beq, 001 is bne; anything else trapped in DECODE
                pc_write  = bus.funct3[0] ? ~bus.zero : bus.zero;
                state_d   = FETCH;
            end
            JAL: begin
                alu_a_sel = 2'b01;
                alu_b_sel = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALU_WB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Outputs are forced low for the whole reset cycle, whatever state we were in.
    assign bus.mem_read       = mem_read       & ~reset;
    assign bus.mem_write      = mem_write      & ~reset;
    assign bus.address_select = address_select & ~reset;
    assign bus.IR_write       = ir_write       & ~reset;
    assign bus.PC_write       = pc_write       & ~reset;
    assign bus.reg_write      = reg_write      & ~reset;
    assign bus.illegal        = illegal        & ~reset;
    assign bus.ALU_A_select   = reset ? 2'b00  : alu_a_sel;
    assign bus.ALU_B_select   = reset ? 2'b00  : alu_b_sel;
    assign bus.result_select  = reset ? 2'b00  : result_sel;
    assign bus.ALU_control    = reset ? 3'b000 : alu_ctrl;
endmodule
